imem_boot_loader: RTL
=====================

Name: imem_boot_loader

Overview:
- Sequences the single-cycle RV32 core through a boot phase: holds the core in reset with the PC frozen, receives a program as a byte stream, writes it word-by-word into instruction memory, then releases the core to run.
- Sits between an external byte source (UART receiver or debug port) and the core top level.
- Drives the instruction-memory write port, the PC load enable and the core reset.
- A new boot request while running halts the core and reloads the program.

Parameters:
- n, 32, data word width (instruction width).
- DEPTH, 64, instruction memory depth in words.
- ADDR_W, 6, word-address width; DEPTH <= 2**ADDR_W.

Ports:
- clk  input  1  system clock.
- areset  input  1  asynchronous, active-low reset.
- boot_req  input  1  single-cycle pulse that starts a program load.
- rx_data  input  8  stream byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction memory write strobe.
- imem_addr  output  ADDR_W  word address for the write.
- imem_wdata  output  n  word to write.
- core_run  output  1  drives the PC load enable.
- core_rst_n  output  1  active-low reset to the core (PC and register file).
- busy  output  1  high in HDR, LOAD and FIN.
- err  output  1  sticky header error.

Behaviour:
- Async reset (areset=0) forces:
  - state=IDLE;
  - all outputs 0, except core_rst_n=0;
  - byte, word and count counters cleared.
- A byte transfer occurs on any rising clk edge where rx_valid && rx_ready. rx_data is sampled only then; rx_valid without rx_ready is ignored.
- States and transitions:
  - IDLE: rx_ready=0, core_run=0, core_rst_n=0. boot_req -> HDR.
  - HDR: rx_ready=1. Collects 4 bytes, little-endian, into the 32-bit word count.
    - On the 4th byte: count==0 -> RUN; count>DEPTH -> ERR; otherwise -> LOAD.
  - LOAD: rx_ready=1. Bytes are assembled little-endian (first byte to bits 7:0).
    - On the cycle the 4th byte of a word is transferred, the assembled word is registered into imem_wdata, imem_addr is set to the current word index, and imem_we=1 on the following cycle for exactly one cycle.
    - Word index increments after each write.
    - The next byte may be transferred in the same cycle imem_we is high (zero-bubble streaming).
    - On transfer of the last byte of the last word -> FIN.
  - FIN: rx_ready=0. imem_we=1 for the last word. Next edge -> RUN.
  - RUN: core_run=1, core_rst_n=1, rx_ready=0, imem_we=0. boot_req -> HDR; core_run and core_rst_n drop at that edge.
  - ERR: err=1, rx_ready=0, core held in reset. boot_req -> HDR, which clears err.
- boot_req in HDR, LOAD or FIN is ignored; a load cannot be restarted mid-transfer except by areset.
- Transfer on the same edge as a state change out of HDR or LOAD: the byte counter is reset on entry to LOAD, so no byte is lost or duplicated.
- imem_addr never exceeds DEPTH-1. The header check guarantees this; the index does not wrap.
- Bytes arriving in RUN, IDLE or ERR are not accepted and not consumed.
- areset asserted mid-load: immediate return to IDLE. Partial memory contents are left as written. The core stays in reset.
- Latency: from the last byte transfer, the core is released (core_rst_n=1) 2 cycles later.

Decomposition:
- Shared package holds:
  - state enumeration (IDLE, HDR, LOAD, FIN, RUN, ERR);
  - BYTES_PER_WORD=4;
  - header size constant.
- One natural sub-module, byte_packer: shift register plus a 2-bit byte counter producing word_valid and the word. It is reused for both the header and payload words.

Test Plan:
- Reset: areset=0 mid-cycle -> all outputs 0 and core_rst_n=0 immediately, without waiting for clk.
- Normal load: boot_req, then stream header 02 00 00 00 and payload 13 05 10 00 93 05 20 00 with rx_valid continuously high:
  - imem_we pulses with addr=0, wdata=0x00100513, then addr=1, wdata=0x00200593;
  - core_rst_n=1 two cycles after the last byte.
- Back-pressure/gaps: same stream with rx_valid toggling 1-0-1 randomly -> identical writes; no extra imem_we pulses.
- Zero count: header 00 00 00 00 -> RUN on the next edge; imem_we never asserted.
- Oversize: header 41 00 00 00 (65 > DEPTH):
  - err=1, core held in reset, rx_ready=0;
  - boot_req followed by a valid header -> err clears.
- Reload from RUN and reset mid-load:
  - boot_req in RUN -> core_run=0 on the next edge; reload completes normally.
  - areset pulsed after 5 payload bytes -> IDLE; no further writes.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Stream format: 4-byte little-endian word count, then count words.
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    FIN,
    RUN,
    ERR
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned HDR_BYTES      = 4;

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// Little-endian byte-to-word packer, shared by header and payload.
// word_valid fires combinationally on the transfer of the last byte.
import imem_boot_loader_pkg::*;

module imem_boot_loader_byte_packer (
  input  logic                          clk,
  input  logic                          areset,
  input  logic                          clr,
  input  logic                          take,
  input  logic [7:0]                    din,
  output logic                          word_valid,
  output logic [BYTES_PER_WORD*8-1:0]   word
);

  localparam int unsigned W = BYTES_PER_WORD * 8;

  logic [1:0]   cnt;
  logic [W-9:0] sr;

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      cnt <= '0;
      sr  <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (take) begin
      cnt <= cnt + 2'd1;
      sr  <= {din, sr[W-9:8]};
    end
  end

  assign word_valid = take && (cnt == 2'(BYTES_PER_WORD - 1));
  assign word       = {din, sr};

endmodule

// File: rtl/imem_boot_loader.sv
// Boot sequencer: holds the core in reset, streams a program into
// instruction memory word by word, then releases the core.
import imem_boot_loader_pkg::*;

module imem_boot_loader #(
  parameter int n      = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              boot_req,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [n-1:0]      imem_wdata,
  output logic              core_run,
  output logic              core_rst_n,
  output logic              busy,
  output logic              err
);

  state_t state;

  logic                        take;
  logic                        start;
  logic                        pk_valid;
  logic [BYTES_PER_WORD*8-1:0] pk_word;
  logic [HDR_BYTES*8-1:0]      hdr_cnt;
  logic [ADDR_W-1:0]           idx;
  logic [ADDR_W-1:0]           last_idx;

  assign take    = rx_valid && rx_ready;
  assign start   = boot_req &&
                   (state == IDLE || state == RUN || state == ERR);
  assign hdr_cnt = pk_word[HDR_BYTES*8-1:0];

  imem_boot_loader_byte_packer u_packer (
    .clk        (clk),
    .areset     (areset),
    .clr        (start),
    .take       (take),
    .din        (rx_data),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state      <= IDLE;
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_run   <= 1'b0;
      core_rst_n <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      idx        <= '0;
      last_idx   <= '0;
    end else begin
      imem_we <= 1'b0;
      unique case (state)
        IDLE, RUN, ERR: begin
          if (boot_req) begin
            state      <= HDR;
            rx_ready   <= 1'b1;
            busy       <= 1'b1;
            core_run   <= 1'b0;
            core_rst_n <= 1'b0;
            err        <= 1'b0;
            idx        <= '0;
          end
        end
        HDR: begin
          if (pk_valid) begin
            if (hdr_cnt == '0) begin
              state      <= RUN;
              rx_ready   <= 1'b0;
              busy       <= 1'b0;
              core_run   <= 1'b1;
              core_rst_n <= 1'b1;
            end else if (hdr_cnt > DEPTH) begin
              state    <= ERR;
              rx_ready <= 1'b0;
              busy     <= 1'b0;
              err      <= 1'b1;
            end else begin
              state    <= LOAD;
              last_idx <= ADDR_W'(hdr_cnt - 32'd1);
            end
          end
        end
        LOAD: begin
          if (pk_valid) begin
            imem_we    <= 1'b1;
            imem_addr  <= idx;
            imem_wdata <= n'(pk_word);
            // Hold the index on the final word so it never wraps.
            if (idx == last_idx) begin
              state    <= FIN;
              rx_ready <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        FIN: begin
          state      <= RUN;
          busy       <= 1'b0;
          core_run   <= 1'b1;
          core_rst_n <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
